// File: rtl/ls273_octal_dff_pkg.sv
// ---------------------------------------------------------------------------
// ls273_octal_dff_pkg
// Shared CPU definitions used by the register storage elements and the
// register-file wrapper.
//   WORD_W    : data bus width of the CPU
//   control_t : decoded control word; one bit per micro-operation
// ---------------------------------------------------------------------------
package ls273_octal_dff_pkg;

    localparam int WORD_W = 8;

    // Field order is the control-word bit order, MSB first.
    typedef struct packed {
        logic load_ir;
        logic load_pc;
        logic load_a;
        logic load_b;
        logic load_x;
        logic do_out;
        logic store_mem;
        logic assert_m;
        logic assert_e;
        logic assert_a;
        logic assert_x;
        logic immediate;
        logic jump_control;
        logic do_subtract;
        logic do_jump;
    } control_t;

    localparam int CONTROL_W = $bits(control_t);

    // IR reloads every cycle; it captures the bus only when load_ir is set
    // and clears to zero otherwise.
    function automatic logic [WORD_W-1:0] ir_next(input control_t ctrl,
                                                   input logic [WORD_W-1:0] dbus);
        return ctrl.load_ir ? dbus : '0;
    endfunction

endpackage

// File: rtl/ls273_octal_dff_regfile.sv
// ---------------------------------------------------------------------------
// ls273_octal_dff_regfile
// CPU register file built from five ls273_octal_dff instances.
//   clk, reset : clock and synchronous active-high reset
//   ctrl       : decoded control word
//   dbus       : CPU data bus
//   ir,a,b,x   : instruction, accumulator, B and index registers
//   out_q      : output port register
// ---------------------------------------------------------------------------
module ls273_octal_dff_regfile
    import ls273_octal_dff_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  control_t          ctrl,
    input  logic [WORD_W-1:0] dbus,
    output logic [WORD_W-1:0] ir,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] out_q
);

    logic [WORD_W-1:0] ir_d;

    assign ir_d = ir_next(ctrl, dbus);

    ls273_octal_dff #(.WIDTH(WORD_W)) u_ir (
        .clk   (clk),
        .reset (reset),
        .load  (1'b1),
        .d     (ir_d),
        .q     (ir)
    );

    ls273_octal_dff #(.WIDTH(WORD_W)) u_a (
        .clk   (clk),
        .reset (reset),
        .load  (ctrl.load_a),
        .d     (dbus),
        .q     (a)
    );

    ls273_octal_dff #(.WIDTH(WORD_W)) u_b (
        .clk   (clk),
        .reset (reset),
        .load  (ctrl.load_b),
        .d     (dbus),
        .q     (b)
    );

    ls273_octal_dff #(.WIDTH(WORD_W)) u_x (
        .clk   (clk),
        .reset (reset),
        .load  (ctrl.load_x),
        .d     (dbus),
        .q     (x)
    );

    ls273_octal_dff #(.WIDTH(WORD_W)) u_out (
        .clk   (clk),
        .reset (reset),
        .load  (ctrl.do_out),
        .d     (dbus),
        .q     (out_q)
    );

endmodule

// File: rtl/ls273_octal_dff.sv
// ---------------------------------------------------------------------------
// ls273_octal_dff
// Edge-triggered D register with synchronous clear and load enable, the
// clock-enable replacement for the 74LS273 gated-clock idiom.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high clear to RESET_VALUE (beats load)
//   load  : capture enable
//   d     : data to capture
//   q     : registered output, straight from flops
// ---------------------------------------------------------------------------
module ls273_octal_dff
    import ls273_octal_dff_pkg::*;
#(
    parameter int               WIDTH       = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $error("ls273_octal_dff: WIDTH must be in 1..64");
        end
    endgenerate

    // The final else is only reachable when load is X/Z; it drives X so an
    // undriven enable shows up on q instead of silently holding.
    always_ff @(posedge clk) begin
        if (reset)
            q <= RESET_VALUE;
        else if (load)
            q <= d;
        else if (!load)
            q <= q;
        else
            q <= 'x;
    end

    a_q_known_after_reset : assert property (
        @(posedge clk) reset |=> !$isunknown(q)
    ) else $error("ls273_octal_dff: q unknown after reset");

    a_load_known : assert property (
        @(posedge clk) !reset |-> !$isunknown(load)
    ) else $error("ls273_octal_dff: load unknown while out of reset");

endmodule

// File: tb/tb_ls273_octal_dff.sv
module tb_ls273_octal_dff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        load8,  load_rv, load1, load16;
    logic [7:0]  d8,     q8;
    logic [7:0]  d_rv,   q_rv;
    logic [0:0]  d1,     q1;
    logic [15:0] d16,    q16;

    int errors = 0;
    int checks = 0;

    ls273_octal_dff u_dut (
        .clk(clk), .reset(reset), .load(load8), .d(d8), .q(q8)
    );

    ls273_octal_dff #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_rv (
        .clk(clk), .reset(reset), .load(load_rv), .d(d_rv), .q(q_rv)
    );

    ls273_octal_dff #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .load(load1), .d(d1), .q(q1)
    );

    ls273_octal_dff #(.WIDTH(16)) u_w16 (
        .clk(clk), .reset(reset), .load(load16), .d(d16), .q(q16)
    );

    // Advance one rising edge and settle just past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load8 = 1'b1; load_rv = 1'b1; load1 = 1'b1; load16 = 1'b1;
        d8 = 8'hA5; d_rv = 8'hA5; d1 = 1'b1; d16 = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (q8 !== 8'h00) begin
                errors++;
                $display("FAIL reset_q8[%0d] got=%h exp=%h", i, q8, 8'h00);
            end
            checks++;
            if (q_rv !== 8'h3C) begin
                errors++;
                $display("FAIL reset_rv[%0d] got=%h exp=%h", i, q_rv, 8'h3C);
            end
            checks++;
            if (q1 !== 1'b0 || q16 !== 16'h0000) begin
                errors++;
                $display("FAIL reset_widths[%0d] got=%h/%h exp=0/0000", i, q1, q16);
            end
        end
        reset = 1'b0;
        load8 = 1'b0; load_rv = 1'b0; load1 = 1'b0; load16 = 1'b0;
    endtask

    task automatic test_load_hold;
        load8 = 1'b1; d8 = 8'h5A;
        load_rv = 1'b1; d_rv = 8'hC5;
        tick();
        checks++;
        if (q8 !== 8'h5A) begin
            errors++;
            $display("FAIL load got=%h exp=%h", q8, 8'h5A);
        end
        checks++;
        if (q_rv !== 8'hC5) begin
            errors++;
            $display("FAIL load_after_reset got=%h exp=%h", q_rv, 8'hC5);
        end
        load8 = 1'b0; d8 = 8'hFF;
        load_rv = 1'b0; d_rv = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q8 !== 8'h5A || q_rv !== 8'hC5) begin
                errors++;
                $display("FAIL hold[%0d] got=%h/%h exp=5a/c5", i, q8, q_rv);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3];
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h80;
        load8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d8 = vals[i];
            tick();
            checks++;
            if (q8 !== vals[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, q8, vals[i]);
            end
        end
        load8 = 1'b0;
    endtask

    task automatic test_reset_load;
        load8 = 1'b1; d8 = 8'h77;
        tick();
        checks++;
        if (q8 !== 8'h77) begin
            errors++;
            $display("FAIL pre_reset_load got=%h exp=%h", q8, 8'h77);
        end
        reset = 1'b1; load8 = 1'b1; d8 = 8'hEE;
        tick();
        checks++;
        if (q8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_beats_load got=%h exp=%h", q8, 8'h00);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (q8 !== 8'hEE) begin
            errors++;
            $display("FAIL load_after_reset_release got=%h exp=%h", q8, 8'hEE);
        end
        load8 = 1'b0;
    endtask

    task automatic test_glitch;
        // Pulse load entirely between two rising edges.
        d8 = 8'hC3;
        #1;
        load8 = 1'b1;
        #5;
        load8 = 1'b0;
        tick();
        checks++;
        if (q8 !== 8'hEE) begin
            errors++;
            $display("FAIL glitch got=%h exp=%h", q8, 8'hEE);
        end
        // Data wiggling mid-cycle with load low has no effect either.
        #2 d8 = 8'h11;
        #2 d8 = 8'h22;
        tick();
        checks++;
        if (q8 !== 8'hEE) begin
            errors++;
            $display("FAIL data_wiggle got=%h exp=%h", q8, 8'hEE);
        end
    endtask

    task automatic test_width_sweep;
        logic [15:0] w;
        load1 = 1'b1;
        d1 = 1'b1;
        tick();
        checks++;
        if (q1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_one got=%b exp=1", q1);
        end
        d1 = 1'b0;
        tick();
        checks++;
        if (q1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_zero got=%b exp=0", q1);
        end
        load1 = 1'b0;

        load16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w = 16'h0001 << i;
            d16 = w;
            tick();
            checks++;
            if (q16 !== w) begin
                errors++;
                $display("FAIL w16_walk[%0d] got=%h exp=%h", i, q16, w);
            end
        end
        load16 = 1'b0;
        d16 = 16'h0000;
        tick();
        checks++;
        if (q16 !== 16'h8000) begin
            errors++;
            $display("FAIL w16_hold got=%h exp=%h", q16, 16'h8000);
        end
    endtask

    initial begin
        reset = 1'b0;
        load8 = 1'b0; load_rv = 1'b0; load1 = 1'b0; load16 = 1'b0;
        d8 = '0; d_rv = '0; d1 = '0; d16 = '0;
        @(negedge clk);
        test_reset();
        test_load_hold();
        test_back_to_back();
        test_reset_load();
        test_glitch();
        test_width_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
